// File: rtl/fib_pkg.sv
// Shared constants and types for the Fibonacci (Zeckendorf) codec.
package fib_pkg;

  localparam int FIB_N_DIGITS = 32;
  localparam int FIB_OUT_W    = 23;

  // Seeds of the weight generator: F(2) and F(3).
  // The encoder uses the same seeds.
  localparam int FIB_SEED_A = 1;
  localparam int FIB_SEED_B = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fib_state_e;

endpackage

// File: rtl/fib_step_gen.sv
// Weight generator for the Fibonacci digits.
// It holds the pair (fa, fb) = (F(i+2), F(i+3)) and advances it one digit per step.
module fib_step_gen
  import fib_pkg::*;
#(
  parameter int W = FIB_OUT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         step,
  output logic [W-1:0] fa
);

  logic [W-1:0] fa_q;
  logic [W-1:0] fb_q;

  // Seed the pair on load and advance it along the sequence on step.
  // The last fb may wrap; that value is never consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fa_q <= '0;
      fb_q <= '0;
    end else if (load) begin
      fa_q <= W'(FIB_SEED_A);
      fb_q <= W'(FIB_SEED_B);
    end else if (step) begin
      fa_q <= fb_q;
      fb_q <= fa_q + fb_q;
    end
  end

  assign fa = fa_q;

endmodule

// File: rtl/fib_canonical_decoder.sv
// Serial Fibonacci-code decoder. It consumes one digit per clock, starting at the LSB.
// It stops early once no set digits remain.
module fib_canonical_decoder
  import fib_pkg::*;
#(
  parameter int N_DIGITS = FIB_N_DIGITS,
  parameter int OUT_W    = FIB_OUT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N_DIGITS-1:0] in_code,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_W-1:0]    out_value,
  output logic                out_err
);

  fib_state_e          state_q;
  logic [N_DIGITS-1:0] sr_q;
  logic [N_DIGITS-1:0] sr_d;
  logic [OUT_W-1:0]    acc_q;
  logic [OUT_W-1:0]    acc_d;
  logic                prev_q;
  logic                err_q;
  logic                err_d;
  logic                out_valid_q;
  logic [OUT_W-1:0]    out_value_q;
  logic                out_err_q;
  logic [OUT_W-1:0]    fa;
  logic                gen_load;
  logic                gen_step;

  assign gen_load = (state_q == IDLE) && in_valid;
  assign gen_step = (state_q == RUN);

  fib_step_gen #(.W(OUT_W)) u_step_gen (
    .clk  (clk),
    .rst  (rst),
    .load (gen_load),
    .step (gen_step),
    .fa   (fa)
  );

  // Work out one digit: add its weight, flag two adjacent ones, and shift the word.
  always_comb begin
    acc_d = acc_q;
    err_d = err_q;
    sr_d  = sr_q >> 1;
    if (sr_q[0]) begin
      acc_d = acc_q + fa;
      if (prev_q) err_d = 1'b1;
    end
  end

  // Control FSM. The result registers are written here so the outputs are registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      acc_q       <= '0;
      prev_q      <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_value_q <= '0;
      out_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sr_q    <= in_code;
            acc_q   <= '0;
            prev_q  <= 1'b0;
            err_q   <= 1'b0;
            state_q <= RUN;
          end
        end
        RUN: begin
          acc_q  <= acc_d;
          err_q  <= err_d;
          prev_q <= sr_q[0];
          sr_q   <= sr_d;
          if (sr_d == '0) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            out_value_q <= acc_d;
            out_err_q   <= err_d;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out_value = out_value_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_fib_canonical_decoder.sv
// Directed bench for fib_canonical_decoder. The expected values are worked out by hand.
module tb_fib_canonical_decoder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_code;
  logic        out_valid;
  logic        out_ready;
  logic [22:0] out_value;
  logic        out_err;

  int tests;
  int fails;

  fib_canonical_decoder #(.N_DIGITS(32), .OUT_W(23)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_code   (in_code),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_value (out_value),
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Time limit for the whole run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv)
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Offer a word in IDLE and return after the accept edge.
  task automatic accept_word(input logic [31:0] code);
    @(negedge clk);
    in_valid = 1'b1;
    in_code  = code;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Count the edges from the accept edge to out_valid, then check latency, value and flag.
  task automatic wait_result(input string tag, input int exp_lat,
                             input logic [22:0] exp_val, input logic exp_err);
    int lat;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_val"}, {9'd0, out_value}, {9'd0, exp_val});
    chk({tag, "_err"}, {31'd0, out_err}, {31'd0, exp_err});
    $display("[TB] %s code=%h value=%0d err=%0d latency=%0d", tag, in_code, out_value, out_err, lat);
  endtask

  // Take the result, then check that the decoder is back in IDLE.
  task automatic pop(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_pop_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_pop_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic decode(input string tag, input logic [31:0] code, input int exp_lat,
                        input logic [22:0] exp_val, input logic exp_err);
    accept_word(code);
    wait_result(tag, exp_lat, exp_val, exp_err);
    pop(tag);
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_code   = '0;
    out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_value", {9'd0, out_value}, 32'd0);
    chk("rst_out_err", {31'd0, out_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Basic cases.
    decode("zero", 32'h0, 1, 23'd0, 1'b0);
    decode("one", 32'h1, 1, 23'd1, 1'b0);
    // Small words.
    decode("b10010", 32'b10010, 5, 23'd10, 1'b0);
    decode("b101", 32'b101, 3, 23'd4, 1'b0);
    // Extreme words.
    decode("x55555555", 32'h5555_5555, 31, 23'd3524577, 1'b0);
    decode("xAAAAAAAA", 32'hAAAA_AAAA, 32, 23'd5702886, 1'b0);
    decode("x80000000", 32'h8000_0000, 32, 23'd3524578, 1'b0);
    // Non-canonical words.
    decode("b11", 32'b11, 2, 23'd3, 1'b1);
    decode("xFFFFFFFF", 32'hFFFF_FFFF, 32, 23'd838855, 1'b1);

    // Backpressure: hold the result and send an in_valid pulse, which must be ignored.
    accept_word(32'b10010);
    wait_result("bp", 5, 23'd10, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = (i == 2);
      in_code  = 32'h3;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_hold_value", {9'd0, out_value}, 32'd10);
      chk("bp_hold_err", {31'd0, out_err}, 32'd0);
      chk("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    pop("bp");
    decode("bp_next", 32'b101, 3, 23'd4, 1'b0);

    // Reset during RUN: drop the word at once and issue no result.
    accept_word(32'h8000_0000);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    chk("mid_run_busy", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_value", {9'd0, out_value}, 32'd0);
    chk("mid_rst_err", {31'd0, out_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) begin
      @(posedge clk);
      #1;
      chk("post_rst_no_valid", {31'd0, out_valid}, 32'd0);
    end
    decode("post_rst", 32'b10010, 5, 23'd10, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
